alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised, registered multi-cycle successor to the combinational 32-bit ALU.
//  Same funct encoding for ops 0-8, plus an iterative shift-add multiply (funct 9).
//  Valid/ready handshake on both sides; full N/Z/C/V flags on the output.
//  Sits between the decode/register-read stage and writeback in the multi-cycle datapath.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands/funct valid
//  in_ready   out  1      high only in IDLE; transfer when in_valid & in_ready
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B / shift amount
//  funct      in   4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT(A),6 SLA,7 SRA,8 SRL,9 MUL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out        out  WIDTH  result
//  flagZ      out  1      out == 0
//  flagN      out  1      out[WIDTH-1]
//  flagC      out  1      carry (ADD), borrow i.e. A<B unsigned (SUB), high-half!=0 (MUL), else 0
//  flagV      out  1      signed overflow (ADD/SUB), else 0
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Single clock clk; rst synchronous active-high, overrides everything incl. an op in flight:
//    state=IDLE, out/flags=0, out_valid=0, busy=0, multiply counter/accumulator cleared.
//  - FSM IDLE -> (accept, funct 0-8 or undefined) -> DONE; IDLE -> (accept, funct 9) -> BUSY;
//    BUSY -> (count==WIDTH-1 step done) -> DONE; DONE -> (out_ready) -> IDLE.
//  - Operands and funct latched on accept; later input changes ignored until next accept.
//  - Latency accept->out_valid: 1 cycle ops 0-8; WIDTH+1 cycles MUL (one partial product/cycle).
//  - Throughput: one op per >=2 cycles; in_ready=0 in BUSY and DONE (no combinational in->out path).
//  - out/flags are registered and held stable while out_valid & !out_ready; change only on rst or
//    on entering DONE.
//  - Arithmetic: ADD/SUB modulo 2^WIDTH. Shifts use full unsigned B; B>=WIDTH gives 0 (SLA, SRL)
//    or WIDTH copies of A[WIDTH-1] (SRA). MUL: unsigned, out = low WIDTH bits of the 2*WIDTH product.
//  - Undefined funct (10-15): treated as single-cycle, out=0, flagZ=1, others 0.
//  - flagZ/flagN always derived from registered out; consistent with out in same cycle.
//  - in_valid while !in_ready: not accepted, no state effect; producer must hold.
// CONFIGURATION
//  ALU_MUL_EN defined: funct 9 runs the iterative multiplier as above (BUSY state, counter,
//    2*WIDTH accumulator present).
//  ALU_MUL_EN undefined: no multiplier hardware, BUSY state unreachable; funct 9 behaves as
//    undefined funct (1-cycle, out=0, flagZ=1).
// TESTING (WIDTH=32, out_ready=1 unless stated)
//  1. ADD 0x7FFFFFFF+1 -> 1 cycle later out=0x80000000, N=1, V=1, C=0, Z=0;
//     ADD 0xFFFFFFFF+1 -> out=0, Z=1, C=1, V=0.
//  2. SUB 3-5 -> out=0xFFFFFFFE, N=1, C=1; SRA 0x80000000 by 40 -> 0xFFFFFFFF;
//     SRL same -> 0, Z=1; SLA 1 by 31 -> 0x80000000.
//  3. MUL 0x10000*0x10000 (macro on) -> out_valid exactly 33 cycles after accept,
//     out=0, Z=1, C=1; busy=1 and in_ready=0 throughout.
//  4. Backpressure: ADD 5+6 with out_ready=0 for 4 cycles -> out=11 held, out_valid=1,
//     in_ready=0; in_valid pulses ignored; on out_ready=1, IDLE next cycle.
//  5. rst asserted mid-MUL (cycle 10) -> next edge out_valid=0, out=0, busy=0, in_ready=1;
//     a new ADD 2+2 then returns out=4.
//  6. funct 9 with ALU_MUL_EN undefined, and funct 15 -> 1-cycle out=0, Z=1, busy never >1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshake and N/Z/C/V flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (funct 9).
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flagZ,
  output logic             flagN,
  output logic             flagC,
  output logic             flagV,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             big;
  logic [SW-1:0]    sh;

  // Single-cycle result, computed from the operands on the accept edge
  always_comb begin
    sum   = {1'b0, A} + {1'b0, B};
    dif   = {1'b0, A} - {1'b0, B};
    big   = B > WIDTH'(WIDTH - 1);
    sh    = B[SW-1:0];
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (funct)
      4'd0: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) &&
                (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) &&
                (dif[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: res = A & B;
      4'd3: res = A | B;
      4'd4: res = A ^ B;
      4'd5: res = ~A;
      4'd6: res = big ? '0 : A << sh;
      4'd7: res = big ? {WIDTH{A[WIDTH-1]}}
                      : WIDTH'($signed(A) >>> sh);
      4'd8: res = big ? '0 : A >> sh;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     psum;
  logic [SW-1:0]      count;

  // Right-shifting accumulator: add A into the high half, shift down one bit
  always_comb begin
    psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (mb[0] ? {1'b0, ma} : '0);
    acc_next = {psum, acc[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      flagZ <= 1'b0;
      flagN <= 1'b0;
      flagC <= 1'b0;
      flagV <= 1'b0;
`ifdef ALU_MUL_EN
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MUL_EN
            if (funct == 4'd9) begin
              state <= BUSY;
              ma    <= A;
              mb    <= B;
              acc   <= '0;
              count <= '0;
            end else
`endif
            begin
              state <= DONE;
              out   <= res;
              flagZ <= (res == '0);
              flagN <= res[WIDTH-1];
              flagC <= res_c;
              flagV <= res_v;
            end
          end
        end
        BUSY: begin
`ifdef ALU_MUL_EN
          acc   <= acc_next;
          mb    <= mb >> 1;
          count <= count + 1'b1;
          if (count == SW'(WIDTH - 1)) begin
            state <= DONE;
            out   <= acc_next[WIDTH-1:0];
            flagZ <= (acc_next[WIDTH-1:0] == '0);
            flagN <= acc_next[WIDTH-1];
            flagC <= |acc_next[2*WIDTH-1:WIDTH];
            flagV <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32).
// Multiplier sequences are built only when ALU_MUL_EN is defined.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   funct;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         flagZ;
  logic         flagN;
  logic         flagC;
  logic         flagV;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .funct(funct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .flagZ(flagZ),
    .flagN(flagN),
    .flagC(flagC),
    .flagV(flagV),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [31:0] o;
    logic [3:0]  fl;
  } vec_t;

  vec_t v[16];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {flagN, flagZ, flagC, flagV};
  endfunction

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0]  f);
    A        = a;
    B        = b;
    funct    = f;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input string nm,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eo,
                         input logic [3:0]  ef);
    int lat;
    bit hs_ok;
    issue(a, b, 4'd9);
    A     = '0;
    B     = '0;
    lat   = 1;
    hs_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) hs_ok = 1'b0;
      step();
      lat++;
    end
    chk({nm, "_lat"}, lat, 33);
    chk({nm, "_busy"}, hs_ok, 1);
    chk({nm, "_out"}, out, eo);
    chk({nm, "_flags"}, flags(), ef);
    step();
  endtask
`endif

  initial begin
    // flags packed as {N, Z, C, V}
    v[0]  = '{32'h7FFFFFFF, 32'h1,        4'd0, 32'h80000000, 4'b1001};
    v[1]  = '{32'hFFFFFFFF, 32'h1,        4'd0, 32'h00000000, 4'b0110};
    v[2]  = '{32'h3,        32'h5,        4'd1, 32'hFFFFFFFE, 4'b1010};
    v[3]  = '{32'h80000000, 32'd40,       4'd7, 32'hFFFFFFFF, 4'b1000};
    v[4]  = '{32'h80000000, 32'd40,       4'd8, 32'h00000000, 4'b0100};
    v[5]  = '{32'h1,        32'd31,       4'd6, 32'h80000000, 4'b1000};
    v[6]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000, 4'b1000};
    v[7]  = '{32'h0F0F0000, 32'h000000F0, 4'd3, 32'h0F0F00F0, 4'b0000};
    v[8]  = '{32'hAAAA5555, 32'hFFFF0000, 4'd4, 32'h55555555, 4'b0000};
    v[9]  = '{32'h12345678, 32'h0,        4'd5, 32'hEDCBA987, 4'b1000};
    v[10] = '{32'h80000000, 32'h1,        4'd1, 32'h7FFFFFFF, 4'b0001};
    v[11] = '{32'hF0000000, 32'd4,        4'd7, 32'hFF000000, 4'b1000};
    v[12] = '{32'hF0000000, 32'd4,        4'd8, 32'h0F000000, 4'b0000};
    v[13] = '{32'h3,        32'd32,       4'd6, 32'h00000000, 4'b0100};
    v[14] = '{32'h5,        32'h6,        4'd15, 32'h00000000, 4'b0100};
    v[15] = '{32'h5,        32'h5,        4'd1, 32'h00000000, 4'b0100};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    funct     = '0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      issue(v[i].a, v[i].b, v[i].f);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_out", i), out, v[i].o);
      chk($sformatf("v%0d_flags", i), flags(), v[i].fl);
      step();
      chk($sformatf("v%0d_idle", i), in_ready, 1);
    end

    // Backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue(32'd5, 32'd6, 4'd0);
    A        = 32'd100;
    B        = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_out", i), out, 11);
      chk($sformatf("bp%0d_ready", i), in_ready, 0);
      in_valid = ~in_valid;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_out", out, 11);

    // Reset while a result is waiting in DONE
    out_ready = 1'b0;
    issue(32'd7, 32'd8, 4'd0);
    chk("rd_pre_out", out, 15);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("rd_valid", out_valid, 0);
    chk("rd_out", out, 0);
    chk("rd_busy", busy, 0);
    chk("rd_ready", in_ready, 1);
    issue(32'd2, 32'd2, 4'd0);
    chk("rd_add_out", out, 4);
    step();

`ifdef ALU_MUL_EN
    run_mul("mul_big", 32'h00010000, 32'h00010000, 32'h0, 4'b0110);
    run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0010);
    run_mul("mul_small", 32'd7, 32'd6, 32'd42, 4'b0000);

    // Reset partway through a multiply
    issue(32'h00010000, 32'h00010000, 4'd9);
    for (int i = 0; i < 9; i++) step();
    chk("rm_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", out_valid, 0);
    chk("rm_out", out, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", in_ready, 1);
    issue(32'd2, 32'd2, 4'd0);
    chk("rm_add_valid", out_valid, 1);
    chk("rm_add_out", out, 4);
    step();
`else
    // Without the multiplier, funct 9 is an undefined op
    issue(32'd3, 32'd3, 4'd9);
    chk("f9_valid", out_valid, 1);
    chk("f9_out", out, 0);
    chk("f9_flags", flags(), 4'b0100);
    step();
    chk("f9_busy", busy, 0);
    chk("f9_ready", in_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
